// File: rtl/jam_search_pkg.sv
// Shared definitions for the jam_search permutation engine: FSM state codes,
// mode encoding and the width derivations used by the top and perm_next.
package jam_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_FETCH = 3'd1;
  localparam state_t S_DRAIN = 3'd2;
  localparam state_t S_CMP   = 3'd3;
  localparam state_t S_NEXTP = 3'd4;
  localparam state_t S_DONE  = 3'd5;

  localparam logic MODE_MIN = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  function automatic int calc_iw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // N costs of COST_W bits each sum to less than 2**(COST_W + clog2(N)).
  function automatic int calc_sum_w(input int n, input int cost_w);
    return cost_w + $clog2(n);
  endfunction

endpackage

// File: rtl/jam_search_perm_next.sv
// Permutation register with a lexicographic next-permutation step.
// init loads identity; req/ack performs one step; last flags the descending order.
module perm_next
  import jam_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = calc_iw(N)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            init,
  input  logic            req,
  output logic            ack,
  output logic            last,
  output logic [N*IW-1:0] perm
);

  logic [IW-1:0] r_perm [N];
  logic [IW-1:0] w_nxt  [N];
  logic [IW-1:0] w_src  [N];
  logic [IW-1:0] w_piv;
  logic [IW-1:0] w_succ;
  logic          w_has_piv;
  logic          r_ack;

  // NOTE: every signal written here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_has_piv = 1'b0;
    w_piv     = '0;
    w_succ    = '0;
    // Rightmost ascent is the pivot; the suffix after it is descending, so the
    // rightmost element above the pivot is the smallest one that is larger.
    for (int i = 0; i < N-1; i++) begin
      if (r_perm[i] < r_perm[i+1]) begin
        w_has_piv = 1'b1;
        w_piv     = IW'(i);
      end
    end
    for (int i = 1; i < N; i++) begin
      if (IW'(i) > w_piv && r_perm[i] > r_perm[w_piv]) w_succ = IW'(i);
    end
    for (int k = 0; k < N; k++) begin
      w_src[k] = IW'(N - k) + w_piv;
      if (IW'(k) < w_piv)         w_nxt[k] = r_perm[k];
      else if (IW'(k) == w_piv)   w_nxt[k] = r_perm[w_succ];
      else if (w_src[k] == w_succ) w_nxt[k] = r_perm[w_piv];
      else                         w_nxt[k] = r_perm[w_src[k]];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: r_perm is N small flops rather than a RAM, so resetting it to
      // identity is cheap and keeps the outputs defined out of reset.
      for (int k = 0; k < N; k++) r_perm[k] <= IW'(k);
      r_ack <= 1'b0;
    end else begin
      r_ack <= req && !r_ack;
      if (init) begin
        for (int k = 0; k < N; k++) r_perm[k] <= IW'(k);
      end else if (req && !r_ack) begin
        r_perm <= w_nxt;
      end
    end
  end

  assign ack  = r_ack;
  assign last = !w_has_piv;

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign perm[g*IW +: IW] = r_perm[g];
  end

endmodule

// File: rtl/jam_search.sv
// Exhaustive job-assignment search: walks all N! permutations, sums costs read
// from an external table and keeps the best total, its match count and first perm.
module jam_search
  import jam_pkg::*;
#(
  parameter  int N      = 8,
  parameter  int COST_W = 7,
  parameter  int MC_W   = 16,
  localparam int IW     = calc_iw(N),
  localparam int SUM_W  = calc_sum_w(N, COST_W)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              mode,
  output logic [IW-1:0]     W,
  output logic [IW-1:0]     J,
  input  logic [COST_W-1:0] Cost,
  output logic              busy,
  output logic              Valid,
  output logic [SUM_W-1:0]  BestCost,
  output logic [MC_W-1:0]   MatchCount,
  output logic [N*IW-1:0]   BestPerm
);

  state_t            r_state;
  logic              r_mode;
  logic              r_first;
  logic              r_rd_vld;
  logic [IW-1:0]     r_w;
  logic [IW-1:0]     r_j;
  logic [SUM_W-1:0]  r_acc;
  logic [SUM_W-1:0]  r_best;
  logic [MC_W-1:0]   r_cnt;
  logic [N*IW-1:0]   r_bperm;
  logic              r_busy;
  logic              r_valid;

  logic [N*IW-1:0]   w_perm;
  logic              w_init;
  logic              w_req;
  logic              w_ack;
  logic              w_last;
  logic [IW-1:0]     w_w_inc;
  logic [SUM_W-1:0]  w_cost_ext;
  logic              w_better;

  assign w_init     = (r_state == S_IDLE) && start;
  assign w_req      = (r_state == S_NEXTP);
  assign w_w_inc    = r_w + 1'b1;
  assign w_cost_ext = {{(SUM_W-COST_W){1'b0}}, Cost};
  assign w_better   = (r_mode == MODE_MAX) ? (r_acc > r_best) : (r_acc < r_best);

  perm_next #(.N(N), .IW(IW)) u_perm (
    .CLK  (CLK),
    .RST  (RST),
    .init (w_init),
    .req  (w_req),
    .ack  (w_ack),
    .last (w_last),
    .perm (w_perm)
  );

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_mode   <= MODE_MIN;
      r_first  <= 1'b0;
      r_rd_vld <= 1'b0;
      r_w      <= '0;
      r_j      <= '0;
      r_acc    <= '0;
      r_best   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      for (int k = 0; k < N; k++) r_bperm[k*IW +: IW] <= IW'(k);
    end else begin
      // Cost arrives one cycle after its address, so add it a cycle late.
      r_rd_vld <= (r_state == S_FETCH);
      if (r_rd_vld) r_acc <= r_acc + w_cost_ext;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode  <= mode;
            r_first <= 1'b1;
            r_w     <= '0;
            r_j     <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (r_w == IW'(N-1)) begin
            r_state <= S_DRAIN;
          end else begin
            r_w <= w_w_inc;
            r_j <= w_perm[w_w_inc*IW +: IW];
          end
        end
        S_DRAIN: r_state <= S_CMP;
        S_CMP: begin
          r_first <= 1'b0;
          if (r_first || w_better) begin
            r_best  <= r_acc;
            r_cnt   <= {{(MC_W-1){1'b0}}, 1'b1};
            r_bperm <= w_perm;
          end else if (r_acc == r_best && !(&r_cnt)) begin
            r_cnt <= r_cnt + 1'b1;
          end
          if (w_last) begin
            r_busy  <= 1'b0;
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_NEXTP;
          end
        end
        S_NEXTP: begin
          if (w_ack) begin
            r_w     <= '0;
            r_j     <= w_perm[IW-1:0];
            r_acc   <= '0;
            r_state <= S_FETCH;
          end
        end
        S_DONE: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign W          = r_w;
  assign J          = r_j;
  assign busy       = r_busy;
  assign Valid      = r_valid;
  assign BestCost   = r_best;
  assign MatchCount = r_cnt;
  assign BestPerm   = r_bperm;

endmodule

// File: tb/tb_jam_search.sv
// Bench for jam_search: five instances (N=3,4,6,4 with MC_W=4, 8) against a
// brute-force lexicographic model, plus literal pins on the model itself.
module tb_jam_search;

  typedef int perm_t [8];

  logic       CLK = 1'b0;
  logic       RST;
  logic       mode;
  logic [4:0] start_v;
  int         tbl6;

  logic [1:0] w3, j3, w4, j4, w4s, j4s;
  logic [2:0] w6, j6, w8, j8;
  logic [6:0] c3, c4, c6, c4s, c8;
  logic       b3, b4, b6, b4s, b8, v3, v4, v6, v4s, v8;
  logic [8:0] bc3, bc4, bc4s;
  logic [9:0] bc6, bc8;
  logic [15:0] mc3, mc4, mc6, mc8;
  logic [3:0] mc4s;
  logic [5:0] bp3;
  logic [7:0] bp4, bp4s;
  logic [17:0] bp6;
  logic [23:0] bp8;

  jam_search #(.N(3)) u3 (.CLK(CLK), .RST(RST), .start(start_v[0]), .mode(mode), .W(w3), .J(j3),
    .Cost(c3), .busy(b3), .Valid(v3), .BestCost(bc3), .MatchCount(mc3), .BestPerm(bp3));
  jam_search #(.N(4)) u4 (.CLK(CLK), .RST(RST), .start(start_v[1]), .mode(mode), .W(w4), .J(j4),
    .Cost(c4), .busy(b4), .Valid(v4), .BestCost(bc4), .MatchCount(mc4), .BestPerm(bp4));
  jam_search #(.N(6)) u6 (.CLK(CLK), .RST(RST), .start(start_v[2]), .mode(mode), .W(w6), .J(j6),
    .Cost(c6), .busy(b6), .Valid(v6), .BestCost(bc6), .MatchCount(mc6), .BestPerm(bp6));
  jam_search #(.N(4), .MC_W(4)) u4s (.CLK(CLK), .RST(RST), .start(start_v[3]), .mode(mode), .W(w4s),
    .J(j4s), .Cost(c4s), .busy(b4s), .Valid(v4s), .BestCost(bc4s), .MatchCount(mc4s), .BestPerm(bp4s));
  jam_search #(.N(8)) u8 (.CLK(CLK), .RST(RST), .start(start_v[4]), .mode(mode), .W(w8), .J(j8),
    .Cost(c8), .busy(b8), .Valid(v8), .BestCost(bc8), .MatchCount(mc8), .BestPerm(bp8));

  initial forever #5 CLK = ~CLK;

  // External cost tables with one cycle of read latency.
  always @(posedge CLK) begin
    c3  <= 7'(3 * w3 + j3);
    c4  <= (w4 == j4) ? 7'd10 : 7'd1;
    c6  <= (tbl6 == 3) ? 7'd127 : 7'd0;
    c4s <= 7'd0;
    c8  <= 7'd0;
  end

  int sel;
  int a_w, a_j, a_best, a_cnt;
  logic a_valid, a_busy;
  perm_t a_perm;

  always_comb begin
    a_w = 0; a_j = 0; a_best = 0; a_cnt = 0; a_valid = 1'b0; a_busy = 1'b0;
    for (int k = 0; k < 8; k++) a_perm[k] = 0;
    case (sel)
      0: begin
        a_w = int'(w3); a_j = int'(j3); a_best = int'(bc3); a_cnt = int'(mc3); a_valid = v3; a_busy = b3;
        for (int k = 0; k < 3; k++) a_perm[k] = int'(bp3[k*2 +: 2]);
      end
      1: begin
        a_w = int'(w4); a_j = int'(j4); a_best = int'(bc4); a_cnt = int'(mc4); a_valid = v4; a_busy = b4;
        for (int k = 0; k < 4; k++) a_perm[k] = int'(bp4[k*2 +: 2]);
      end
      2: begin
        a_w = int'(w6); a_j = int'(j6); a_best = int'(bc6); a_cnt = int'(mc6); a_valid = v6; a_busy = b6;
        for (int k = 0; k < 6; k++) a_perm[k] = int'(bp6[k*3 +: 3]);
      end
      3: begin
        a_w = int'(w4s); a_j = int'(j4s); a_best = int'(bc4s); a_cnt = int'(mc4s); a_valid = v4s; a_busy = b4s;
        for (int k = 0; k < 4; k++) a_perm[k] = int'(bp4s[k*2 +: 2]);
      end
      default: begin
        a_w = int'(w8); a_j = int'(j8); a_best = int'(bc8); a_cnt = int'(mc8); a_valid = v8; a_busy = b8;
        for (int k = 0; k < 8; k++) a_perm[k] = int'(bp8[k*3 +: 3]);
      end
    endcase
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int cost_of(input int tbl, input int w, input int j);
    case (tbl)
      0:       return 3 * w + j;
      1:       return (w == j) ? 10 : 1;
      3:       return 127;
      default: return 0;
    endcase
  endfunction

  // Brute force: counting n-digit base-n tuples upward visits permutations in
  // lexicographic order; non-permutations are skipped.
  function automatic void model(input int n, input int tbl, input int md, input int mc_w,
                                output int best, output int cnt, output perm_t perm);
    perm_t tup;
    int x, sum, seen;
    bit first, dup;
    best = 0; cnt = 0; first = 1'b1;
    for (int k = 0; k < 8; k++) begin perm[k] = 0; tup[k] = 0; end
    for (int t = 0; t < n**n; t++) begin
      x = t; seen = 0; dup = 1'b0; sum = 0;
      for (int w = n-1; w >= 0; w--) begin tup[w] = x % n; x = x / n; end
      for (int w = 0; w < n; w++) begin
        if (seen[tup[w]]) dup = 1'b1;
        seen[tup[w]] = 1'b1;
        sum += cost_of(tbl, w, tup[w]);
      end
      if (!dup) begin
        if (first || (md == 1 ? sum > best : sum < best)) begin
          best = sum; cnt = 1; perm = tup; first = 1'b0;
        end else if (sum == best && cnt < (1 << mc_w) - 1) begin
          cnt++;
        end
      end
    end
  endfunction

  int    exp_best, exp_cnt, exp_n;
  perm_t exp_perm;
  int    valid_seen = 0;
  int    last_w_rec = -1;
  int    hist_w [8];
  int    hist_j [8];

  // Single compare process: tracks the read stream and checks results on Valid.
  always @(negedge CLK) begin
    if (a_w != last_w_rec) begin
      for (int k = 0; k < 7; k++) begin hist_w[k] = hist_w[k+1]; hist_j[k] = hist_j[k+1]; end
      hist_w[7] = a_w; hist_j[7] = a_j; last_w_rec = a_w;
    end
    if (a_valid) begin
      valid_seen++;
      check("best_cost", a_best, exp_best);
      check("match_count", a_cnt, exp_cnt);
      for (int k = 0; k < exp_n; k++) check($sformatf("best_perm[%0d]", k), a_perm[k], exp_perm[k]);
      check("busy_low_at_valid", a_busy, 0);
      for (int k = 0; k < exp_n; k++) begin
        check($sformatf("last_perm_w[%0d]", k), hist_w[8-exp_n+k], k);
        check($sformatf("last_perm_j[%0d]", k), hist_j[8-exp_n+k], exp_n-1-k);
      end
    end
  end

  task automatic run_search(input int s, input int n, input int tbl, input int md,
                            input int mc_w, input bit poke);
    int  v0;
    bit  got;
    sel = s;
    model(n, tbl, md, mc_w, exp_best, exp_cnt, exp_perm);
    exp_n = n;
    v0 = valid_seen;
    @(negedge CLK); mode = md[0]; start_v[s] = 1'b1;
    @(negedge CLK); start_v[s] = 1'b0;
    if (poke) begin
      repeat (5) @(negedge CLK);
      mode = ~md[0]; start_v[s] = 1'b1;
      @(negedge CLK); start_v[s] = 1'b0;
    end
    got = 1'b0;
    for (int c = 0; c < 20000 && !got; c++) begin
      @(posedge CLK);
      got = (valid_seen != v0);
    end
    check($sformatf("done_in_budget_n%0d", n), got, 1);
    repeat (4) @(negedge CLK);
    check("one_valid_pulse", valid_seen - v0, 1);
    check("busy_after_done", a_busy, 0);
    check("result_held", a_best, exp_best);
  endtask

  task automatic check_reset_state(input string tag, input int n);
    check({tag, "_W"}, a_w, 0);
    check({tag, "_J"}, a_j, 0);
    check({tag, "_busy"}, a_busy, 0);
    check({tag, "_valid"}, a_valid, 0);
    check({tag, "_best"}, a_best, 0);
    check({tag, "_count"}, a_cnt, 0);
    for (int k = 0; k < n; k++) check($sformatf("%s_perm[%0d]", tag, k), a_perm[k], k);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    b, c, v0;
    bit    found;
    perm_t p;
    perm_t exp2;

    RST = 1'b1; start_v = '0; mode = 1'b0; tbl6 = 2; sel = 4;
    for (int k = 0; k < 8; k++) begin hist_w[k] = -1; hist_j[k] = -1; end
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    #1;
    check_reset_state("reset", 8);

    // Literal pins on the model.
    model(3, 0, 0, 16, b, c, p);
    check("pin_n3_best", b, 12); check("pin_n3_cnt", c, 6); check("pin_n3_p2", p[2], 2);
    model(4, 1, 0, 16, b, c, p);
    check("pin_n4min_best", b, 4); check("pin_n4min_cnt", c, 9);
    check("pin_n4min_p0", p[0], 1); check("pin_n4min_p3", p[3], 2);
    model(4, 1, 1, 16, b, c, p);
    check("pin_n4max_best", b, 40); check("pin_n4max_cnt", c, 1);
    model(6, 3, 1, 16, b, c, p);
    check("pin_n6max_best", b, 762); check("pin_n6max_cnt", c, 720);
    model(4, 2, 0, 4, b, c, p);
    check("pin_sat_cnt", c, 15);

    run_search(0, 3, 0, 0, 16, 1'b0);
    run_search(1, 4, 1, 0, 16, 1'b1);   // second start with flipped mode while busy
    run_search(1, 4, 1, 1, 16, 1'b0);

    // Reset in the middle of FETCH aborts the run without a Valid.
    sel = 1; v0 = valid_seen;
    @(negedge CLK); mode = 1'b0; start_v[1] = 1'b1;
    @(negedge CLK); start_v[1] = 1'b0;
    check("busy_after_start", a_busy, 1);
    @(negedge CLK); RST = 1'b1;
    #1;
    check_reset_state("abort", 4);
    @(negedge CLK); RST = 1'b0;
    repeat (40) @(negedge CLK);
    check("no_valid_after_abort", valid_seen - v0, 0);
    run_search(1, 4, 1, 0, 16, 1'b0);

    tbl6 = 2; run_search(2, 6, 2, 0, 16, 1'b0);
    tbl6 = 3; run_search(2, 6, 3, 1, 16, 1'b0);
    run_search(3, 4, 2, 0, 4, 1'b0);

    // N=8: first permutation reads in order, then the second permutation.
    sel = 4; v0 = valid_seen;
    @(negedge CLK); mode = 1'b0; start_v[4] = 1'b1;
    @(negedge CLK); start_v[4] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("n8_first_w[%0d]", k), a_w, k);
      check($sformatf("n8_first_j[%0d]", k), a_j, k);
      @(negedge CLK);
    end
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      if (a_w == 0) found = 1'b1;
      else @(negedge CLK);
    end
    check("n8_second_perm_started", found, 1);
    exp2 = '{0, 1, 2, 3, 4, 5, 7, 6};
    for (int k = 0; k < 8; k++) begin
      check($sformatf("n8_second_j[%0d]", k), a_j, exp2[k]);
      @(negedge CLK);
    end
    RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    #1;
    check_reset_state("n8_abort", 8);
    repeat (10) @(negedge CLK);
    check("n8_no_valid", valid_seen - v0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
